// File: rtl/ibex_wb_result_buffer.sv
`default_nettype none
// ============================================================================
// Module      : ibex_wb_result_buffer
// Description : Writeback result buffer. It queues EX results in a small FIFO
//               and arbitrates them, together with unstallable LSU load data,
//               onto a registered register-file write port. Pending writes are
//               forwarded to the ID operand muxes.
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_wb_result_buffer #(
    parameter int Depth = 2,
    parameter bit WbFwd = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ex_valid_i,
    output logic        ex_ready_o,
    input  logic [31:0] ex_result_i,
    input  logic [4:0]  ex_rd_addr_i,
    input  logic        ex_rd_we_i,
    input  logic        lsu_rvalid_i,
    input  logic [31:0] lsu_rdata_i,
    input  logic [4:0]  lsu_rd_addr_i,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    input  logic [4:0]  fwd_raddr_a_i,
    output logic        fwd_valid_a_o,
    output logic [31:0] fwd_data_a_o,
    input  logic [4:0]  fwd_raddr_b_i,
    output logic        fwd_valid_b_o,
    output logic [31:0] fwd_data_b_o,
    output logic        busy_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);
    localparam logic [CntW-1:0] c_depth = CntW'(Depth);
    localparam logic [PtrW-1:0] c_last  = PtrW'(Depth - 1);

    logic [4:0]      r_mem_addr [Depth];
    logic [31:0]     r_mem_data [Depth];
    logic [PtrW-1:0] r_wptr;
    logic [PtrW-1:0] r_rptr;
    logic [CntW-1:0] r_count;
    logic            r_rf_we;
    logic [4:0]      r_rf_waddr;
    logic [31:0]     r_rf_wdata;

    logic            w_pop;
    logic            w_ready;
    logic            w_push;
    logic            w_bypass;
    logic            w_enq;
    logic            w_fwd_valid_a;
    logic [31:0]     w_fwd_data_a;
    logic            w_fwd_valid_b;
    logic [31:0]     w_fwd_data_b;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == c_last) ? '0 : p + PtrW'(1);
    endfunction

    // The LSU owns the write port whenever it is valid, so pops only happen without it.
    assign w_pop    = ~lsu_rvalid_i & (r_count != '0);
    assign w_ready  = (r_count < c_depth) | w_pop;
    assign w_push   = ex_valid_i & w_ready & ex_rd_we_i & (ex_rd_addr_i != 5'd0);
    assign w_bypass = w_push & ~lsu_rvalid_i & (r_count == '0);
    assign w_enq    = w_push & ~w_bypass;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= 5'd0;
            r_rf_wdata <= 32'd0;
        end else begin
            if (w_enq) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            case ({w_enq, w_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase

            if (lsu_rvalid_i) begin
                r_rf_we    <= (lsu_rd_addr_i != 5'd0);
                r_rf_waddr <= lsu_rd_addr_i;
                r_rf_wdata <= lsu_rdata_i;
            end else if (w_pop) begin
                r_rf_we    <= 1'b1;
                r_rf_waddr <= r_mem_addr[r_rptr];
                r_rf_wdata <= r_mem_data[r_rptr];
            end else if (w_bypass) begin
                r_rf_we    <= 1'b1;
                r_rf_waddr <= ex_rd_addr_i;
                r_rf_wdata <= ex_result_i;
            end else begin
                r_rf_we    <= 1'b0;
            end
        end
    end

    // Storage is left unreset; r_count alone decides which slots are meaningful.
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_mem_addr[r_wptr] <= ex_rd_addr_i;
            r_mem_data[r_wptr] <= ex_result_i;
        end
    end

    // Scan oldest to youngest so later (younger) matches override earlier ones.
    always_comb begin
        logic [PtrW-1:0] p;
        w_fwd_valid_a = 1'b0;
        w_fwd_data_a  = 32'd0;
        w_fwd_valid_b = 1'b0;
        w_fwd_data_b  = 32'd0;
        p             = r_rptr;
        if (r_rf_we && (fwd_raddr_a_i != 5'd0) && (r_rf_waddr == fwd_raddr_a_i)) begin
            w_fwd_valid_a = 1'b1;
            w_fwd_data_a  = r_rf_wdata;
        end
        if (r_rf_we && (fwd_raddr_b_i != 5'd0) && (r_rf_waddr == fwd_raddr_b_i)) begin
            w_fwd_valid_b = 1'b1;
            w_fwd_data_b  = r_rf_wdata;
        end
        for (int i = 0; i < Depth; i++) begin
            if (CntW'(i) < r_count) begin
                if ((fwd_raddr_a_i != 5'd0) && (r_mem_addr[p] == fwd_raddr_a_i)) begin
                    w_fwd_valid_a = 1'b1;
                    w_fwd_data_a  = r_mem_data[p];
                end
                if ((fwd_raddr_b_i != 5'd0) && (r_mem_addr[p] == fwd_raddr_b_i)) begin
                    w_fwd_valid_b = 1'b1;
                    w_fwd_data_b  = r_mem_data[p];
                end
            end
            p = ptr_inc(p);
        end
    end

    generate
        if (WbFwd) begin : g_fwd
            assign fwd_valid_a_o = w_fwd_valid_a;
            assign fwd_data_a_o  = w_fwd_data_a;
            assign fwd_valid_b_o = w_fwd_valid_b;
            assign fwd_data_b_o  = w_fwd_data_b;
        end else begin : g_no_fwd
            assign fwd_valid_a_o = 1'b0;
            assign fwd_data_a_o  = 32'd0;
            assign fwd_valid_b_o = 1'b0;
            assign fwd_data_b_o  = 32'd0;
        end
    endgenerate

    assign ex_ready_o = w_ready;
    assign rf_we_o    = r_rf_we;
    assign rf_waddr_o = r_rf_waddr;
    assign rf_wdata_o = r_rf_wdata;
    assign busy_o     = (r_count != '0) | r_rf_we;

endmodule
`default_nettype wire

// File: tb/tb_ibex_wb_result_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ibex_wb_result_buffer
// Description : Directed vector table, reset sequence and randomized traffic
//               checked against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ibex_wb_result_buffer;

    localparam int  DEPTH = 2;
    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        ex_valid_i = 1'b0;
    logic        ex_ready_o;
    logic [31:0] ex_result_i = 32'd0;
    logic [4:0]  ex_rd_addr_i = 5'd0;
    logic        ex_rd_we_i = 1'b0;
    logic        lsu_rvalid_i = 1'b0;
    logic [31:0] lsu_rdata_i = 32'd0;
    logic [4:0]  lsu_rd_addr_i = 5'd0;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic [4:0]  fwd_raddr_a_i = 5'd0;
    logic        fwd_valid_a_o;
    logic [31:0] fwd_data_a_o;
    logic [4:0]  fwd_raddr_b_i = 5'd0;
    logic        fwd_valid_b_o;
    logic [31:0] fwd_data_b_o;
    logic        busy_o;

    always #5 clk = ~clk;

    ibex_wb_result_buffer #(.Depth(DEPTH), .WbFwd(1'b1)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .ex_valid_i    (ex_valid_i),
        .ex_ready_o    (ex_ready_o),
        .ex_result_i   (ex_result_i),
        .ex_rd_addr_i  (ex_rd_addr_i),
        .ex_rd_we_i    (ex_rd_we_i),
        .lsu_rvalid_i  (lsu_rvalid_i),
        .lsu_rdata_i   (lsu_rdata_i),
        .lsu_rd_addr_i (lsu_rd_addr_i),
        .rf_we_o       (rf_we_o),
        .rf_waddr_o    (rf_waddr_o),
        .rf_wdata_o    (rf_wdata_o),
        .fwd_raddr_a_i (fwd_raddr_a_i),
        .fwd_valid_a_o (fwd_valid_a_o),
        .fwd_data_a_o  (fwd_data_a_o),
        .fwd_raddr_b_i (fwd_raddr_b_i),
        .fwd_valid_b_o (fwd_valid_b_o),
        .fwd_data_b_o  (fwd_data_b_o),
        .busy_o        (busy_o)
    );

    typedef struct {
        logic        ev;
        logic        ewe;
        logic [4:0]  ea;
        logic [31:0] ed;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic [4:0]  ra;
        logic [4:0]  rb;
    } in_t;

    typedef struct {
        in_t         i;
        logic        rdy;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        busy;
        logic        fva;
        logic [31:0] fda;
        logic        fvb;
        logic [31:0] fdb;
    } vec_t;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: pending EX results in acceptance order, plus the write port.
    ent_t        q[$];
    logic        m_we = 1'b0;
    logic [4:0]  m_wa = 5'd0;
    logic [31:0] m_wd = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    function automatic logic m_ready(input logic lv);
        return (q.size() < DEPTH) || (!lv && q.size() > 0);
    endfunction

    function automatic void m_fwd(input logic [4:0] ra, output logic v, output logic [31:0] d);
        v = 1'b0;
        d = 32'd0;
        if (ra == 5'd0) return;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].a == ra) begin
                v = 1'b1;
                d = q[i].d;
                return;
            end
        end
        if (m_we && m_wa == ra) begin
            v = 1'b1;
            d = m_wd;
        end
    endfunction

    task automatic model_step(input in_t s);
        logic push;
        ent_t e;
        push = s.ev && m_ready(s.lv) && s.ewe && (s.ea != 5'd0);
        if (s.lv) begin
            m_we = (s.la != 5'd0);
            m_wa = s.la;
            m_wd = s.ld;
        end else if (q.size() > 0) begin
            e    = q.pop_front();
            m_we = 1'b1;
            m_wa = e.a;
            m_wd = e.d;
        end else if (push) begin
            m_we = 1'b1;
            m_wa = s.ea;
            m_wd = s.ed;
            push = 1'b0;
        end else begin
            m_we = 1'b0;
        end
        if (push) q.push_back('{a: s.ea, d: s.ed});
    endtask

    task automatic drive(input in_t s);
        ex_valid_i    = s.ev;
        ex_rd_we_i    = s.ewe;
        ex_rd_addr_i  = s.ea;
        ex_result_i   = s.ed;
        lsu_rvalid_i  = s.lv;
        lsu_rd_addr_i = s.la;
        lsu_rdata_i   = s.ld;
        fwd_raddr_a_i = s.ra;
        fwd_raddr_b_i = s.rb;
    endtask

    task automatic check_model(input in_t s);
        logic        v;
        logic [31:0] d;
        chk("mdl.ready", 32'(ex_ready_o), 32'(m_ready(s.lv)));
        chk("mdl.rf_we", 32'(rf_we_o), 32'(m_we));
        chk("mdl.rf_waddr", 32'(rf_waddr_o), 32'(m_wa));
        chk("mdl.rf_wdata", rf_wdata_o, m_wd);
        chk("mdl.busy", 32'(busy_o), 32'((q.size() > 0) || m_we));
        m_fwd(s.ra, v, d);
        chk("mdl.fwd_valid_a", 32'(fwd_valid_a_o), 32'(v));
        if (v) chk("mdl.fwd_data_a", fwd_data_a_o, d);
        m_fwd(s.rb, v, d);
        chk("mdl.fwd_valid_b", 32'(fwd_valid_b_o), 32'(v));
        if (v) chk("mdl.fwd_data_b", fwd_data_b_o, d);
    endtask

    task automatic run(input in_t s);
        drive(s);
        #1;
        check_model(s);
        @(posedge clk);
        model_step(s);
        @(negedge clk);
    endtask

    function automatic in_t idle(input logic [4:0] ra, input logic [4:0] rb);
        return '{F, F, 5'd0, 32'd0, F, 5'd0, 32'd0, ra, rb};
    endfunction

    vec_t vecs[19];

    initial begin
        in_t s;
        vecs[0]  = '{'{T, T, 5'd5, 32'hDEADBEEF, F, 5'd0, 32'd0, 5'd5, 5'd0},
                     T, F, 5'd0, 32'd0, F, F, 32'd0, F, 32'd0};
        vecs[1]  = '{idle(5'd5, 5'd0), T, T, 5'd5, 32'hDEADBEEF, T, T, 32'hDEADBEEF, F, 32'd0};
        vecs[2]  = '{idle(5'd5, 5'd0), T, F, 5'd5, 32'hDEADBEEF, F, F, 32'd0, F, 32'd0};
        vecs[3]  = '{'{T, T, 5'd1, 32'h101, T, 5'd10, 32'hA0, 5'd1, 5'd10},
                     T, F, 5'd5, 32'hDEADBEEF, F, F, 32'd0, F, 32'd0};
        vecs[4]  = '{'{T, T, 5'd2, 32'h102, T, 5'd11, 32'hA1, 5'd1, 5'd10},
                     T, T, 5'd10, 32'hA0, T, T, 32'h101, T, 32'hA0};
        vecs[5]  = '{'{T, T, 5'd3, 32'h103, T, 5'd12, 32'hA2, 5'd1, 5'd2},
                     F, T, 5'd11, 32'hA1, T, T, 32'h101, T, 32'h102};
        vecs[6]  = '{'{T, T, 5'd3, 32'h103, F, 5'd0, 32'd0, 5'd3, 5'd12},
                     T, T, 5'd12, 32'hA2, T, F, 32'd0, T, 32'hA2};
        vecs[7]  = '{idle(5'd3, 5'd1), T, T, 5'd1, 32'h101, T, T, 32'h103, T, 32'h101};
        vecs[8]  = '{idle(5'd2, 5'd3), T, T, 5'd2, 32'h102, T, T, 32'h102, T, 32'h103};
        vecs[9]  = '{idle(5'd3, 5'd2), T, T, 5'd3, 32'h103, T, T, 32'h103, F, 32'd0};
        vecs[10] = '{'{F, F, 5'd0, 32'd0, T, 5'd20, 32'h55, 5'd3, 5'd0},
                     T, F, 5'd3, 32'h103, F, F, 32'd0, F, 32'd0};
        vecs[11] = '{'{T, T, 5'd7, 32'h11, T, 5'd21, 32'h66, 5'd20, 5'd7},
                     T, T, 5'd20, 32'h55, T, T, 32'h55, F, 32'd0};
        vecs[12] = '{'{T, T, 5'd7, 32'h22, T, 5'd22, 32'h77, 5'd7, 5'd0},
                     T, T, 5'd21, 32'h66, T, T, 32'h11, F, 32'd0};
        vecs[13] = '{idle(5'd7, 5'd0), T, T, 5'd22, 32'h77, T, T, 32'h22, F, 32'd0};
        vecs[14] = '{idle(5'd7, 5'd22), T, T, 5'd7, 32'h11, T, T, 32'h22, F, 32'd0};
        vecs[15] = '{idle(5'd7, 5'd0), T, T, 5'd7, 32'h22, T, T, 32'h22, F, 32'd0};
        vecs[16] = '{'{T, T, 5'd0, 32'h99, T, 5'd0, 32'h88, 5'd0, 5'd7},
                     T, F, 5'd7, 32'h22, F, F, 32'd0, F, 32'd0};
        vecs[17] = '{'{T, F, 5'd9, 32'h33, F, 5'd0, 32'd0, 5'd0, 5'd9},
                     T, F, 5'd0, 32'h88, F, F, 32'd0, F, 32'd0};
        vecs[18] = '{idle(5'd9, 5'd0), T, F, 5'd0, 32'h88, F, F, 32'd0, F, 32'd0};

        // Reset state
        drive(idle(5'd5, 5'd0));
        repeat (2) @(negedge clk);
        #1;
        chk("reset.rf_we", 32'(rf_we_o), 32'd0);
        chk("reset.rf_waddr", 32'(rf_waddr_o), 32'd0);
        chk("reset.rf_wdata", rf_wdata_o, 32'd0);
        chk("reset.ready", 32'(ex_ready_o), 32'd1);
        chk("reset.busy", 32'(busy_o), 32'd0);
        chk("reset.fwd_valid_a", 32'(fwd_valid_a_o), 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;

        // Directed vectors
        for (int k = 0; k < 19; k++) begin
            drive(vecs[k].i);
            #1;
            check_model(vecs[k].i);
            chk($sformatf("tbl[%0d].ready", k), 32'(ex_ready_o), 32'(vecs[k].rdy));
            chk($sformatf("tbl[%0d].rf_we", k), 32'(rf_we_o), 32'(vecs[k].we));
            chk($sformatf("tbl[%0d].rf_waddr", k), 32'(rf_waddr_o), 32'(vecs[k].wa));
            chk($sformatf("tbl[%0d].rf_wdata", k), rf_wdata_o, vecs[k].wd);
            chk($sformatf("tbl[%0d].busy", k), 32'(busy_o), 32'(vecs[k].busy));
            chk($sformatf("tbl[%0d].fwd_valid_a", k), 32'(fwd_valid_a_o), 32'(vecs[k].fva));
            chk($sformatf("tbl[%0d].fwd_valid_b", k), 32'(fwd_valid_b_o), 32'(vecs[k].fvb));
            if (vecs[k].fva) chk($sformatf("tbl[%0d].fwd_data_a", k), fwd_data_a_o, vecs[k].fda);
            if (vecs[k].fvb) chk($sformatf("tbl[%0d].fwd_data_b", k), fwd_data_b_o, vecs[k].fdb);
            @(posedge clk);
            model_step(vecs[k].i);
            @(negedge clk);
        end

        // Asynchronous reset with a full FIFO and an active write
        run('{T, T, 5'd14, 32'h14, T, 5'd13, 32'h13, 5'd0, 5'd0});
        run('{T, T, 5'd16, 32'h16, T, 5'd15, 32'h15, 5'd0, 5'd0});
        drive(idle(5'd14, 5'd15));
        #1;
        chk("prerst.rf_we", 32'(rf_we_o), 32'd1);
        chk("prerst.busy", 32'(busy_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("rst.rf_we", 32'(rf_we_o), 32'd0);
        chk("rst.ready", 32'(ex_ready_o), 32'd1);
        chk("rst.busy", 32'(busy_o), 32'd0);
        chk("rst.rf_waddr", 32'(rf_waddr_o), 32'd0);
        chk("rst.fwd_valid_a", 32'(fwd_valid_a_o), 32'd0);
        chk("rst.fwd_valid_b", 32'(fwd_valid_b_o), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        q.delete();
        m_we = 1'b0;
        m_wa = 5'd0;
        m_wd = 32'd0;
        repeat (4) run(idle(5'd14, 5'd16));

        // Randomized traffic against the reference model
        for (int n = 0; n < 2000; n++) begin
            s.ev  = ($urandom_range(0, 9) < 6);
            s.ewe = ($urandom_range(0, 9) < 9);
            s.ea  = 5'($urandom_range(0, 7));
            s.ed  = $urandom;
            s.lv  = ($urandom_range(0, 9) < 3);
            s.la  = 5'($urandom_range(0, 7));
            s.ld  = $urandom;
            s.ra  = 5'($urandom_range(0, 7));
            s.rb  = 5'($urandom_range(0, 7));
            run(s);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
